// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module : alu_arbiter
// Brief  : Two-port round-robin sequencer sharing one combinational 32-bit ALU.
// Rev    : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req1_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] rsp0_result,
    output logic [31:0] rsp1_result,
    output logic        rsp0_zero,
    output logic        rsp1_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluop,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] C_LAST_CNT = 4'(ALU_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_last_grant;
    logic        r_grant_id;
    logic        r_busy;
    logic [1:0]  r_rsp_valid;
    logic [31:0] r_rsp0_result;
    logic [31:0] r_rsp1_result;
    logic        r_rsp0_zero;
    logic        r_rsp1_zero;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [3:0]  r_alu_op;

    logic w_pick;
    logic w_accept;
    logic w_exec_done;
    logic w_rsp_hs;

    // On a tie the port that was not served last wins; otherwise the lone requester.
    assign w_pick      = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept    = (r_state == IDLE) & (req0_valid | req1_valid);
    assign req0_ready  = w_accept & ~w_pick;
    assign req1_ready  = w_accept & w_pick;
    assign w_exec_done = (r_state == EXEC) && (r_cnt == C_LAST_CNT);
    assign w_rsp_hs    = (r_state == RESP) &&
                         (r_grant_id ? (r_rsp_valid[1] & rsp1_ready)
                                     : (r_rsp_valid[0] & rsp0_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_next = EXEC;
            EXEC:    if (w_exec_done) w_next = RESP;
            RESP:    if (w_rsp_hs)    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= 4'd0;
            r_last_grant  <= 1'b1;
            r_grant_id    <= 1'b0;
            r_busy        <= 1'b0;
            r_rsp_valid   <= 2'b00;
            r_rsp0_result <= 32'd0;
            r_rsp1_result <= 32'd0;
            r_rsp0_zero   <= 1'b0;
            r_rsp1_zero   <= 1'b0;
            r_alu_a       <= 32'd0;
            r_alu_b       <= 32'd0;
            r_alu_op      <= 4'd0;
        end else begin
            r_busy <= (w_next != IDLE);
            if (w_accept) begin
                r_cnt        <= 4'd0;
                r_grant_id   <= w_pick;
                r_last_grant <= w_pick;
                r_alu_a      <= w_pick ? req1_a  : req0_a;
                r_alu_b      <= w_pick ? req1_b  : req0_b;
                r_alu_op     <= w_pick ? req1_op : req0_op;
            end else if (r_state == EXEC) begin
                r_cnt <= r_cnt + 4'd1;
            end
            // Only the served port's response register is ever written.
            if (w_exec_done) begin
                r_rsp_valid[r_grant_id] <= 1'b1;
                if (r_grant_id) begin
                    r_rsp1_result <= alu_result;
                    r_rsp1_zero   <= alu_zero;
                end else begin
                    r_rsp0_result <= alu_result;
                    r_rsp0_zero   <= alu_zero;
                end
            end
            if (w_rsp_hs) begin
                r_rsp_valid[r_grant_id] <= 1'b0;
            end
        end
    end

    assign rsp0_valid  = r_rsp_valid[0];
    assign rsp1_valid  = r_rsp_valid[1];
    assign rsp0_result = r_rsp0_result;
    assign rsp1_result = r_rsp1_result;
    assign rsp0_zero   = r_rsp0_zero;
    assign rsp1_zero   = r_rsp1_zero;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_aluop   = r_alu_op;
    assign busy        = r_busy;
    assign grant_id    = r_grant_id;

endmodule
`default_nettype wire
